// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by fetch, decode and the later pipeline registers.
package pipeline_pkg;
  localparam int PC_W       = 32;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the decode handshake.
interface if_stage_if;
  import pipeline_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               stall;
  logic               valid_out;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;

  // Handshake: an instruction transfers to decode in every cycle where valid_out=1 and stall=0,
  // unless redirect_valid is high (the redirect discards it). instr_out/pc_out hold while stalled.
  modport master (
    output imem_req, imem_addr, valid_out, instr_out, pc_out,
    input  imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, valid_out, instr_out, pc_out,
    output imem_rdata, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/if_skid_fifo.sv
// Two-entry {pc, instr} queue between instruction memory and decode; flush wins over push/pop.
module if_skid_fifo
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, memory request issue, squash of redirected returns.
// Optional build macro IF_PERF_CNT_EN adds saturating pop / stall-cycle performance counters.
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  if_stage_if.master   bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic            squash;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            pop;
  logic            push;
  logic            issue;
  logic [2:0]      occupancy;

  // A redirect discards the head, so it is never counted as consumed.
  assign pop       = bus.valid_out && !bus.stall && !bus.redirect_valid;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = rst_n && !bus.redirect_valid && (occupancy < 3'd2);
  assign push      = inflight && !squash && !bus.redirect_valid;
  assign push_data = '{pc: inflight_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      squash      <= 1'b0;
    end else begin
      inflight <= issue;
      squash   <= bus.redirect_valid;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
    end
  end

  if_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.valid_out = (count != 2'd0);
  assign bus.instr_out = bus.valid_out ? head.instr : NOP_INSTR;
  assign bus.pc_out    = bus.valid_out ? head.pc : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop && (perf_fetch_cnt != '1)) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (bus.valid_out && bus.stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage at the head of the five-stage pipeline, directly upstream of the decode stage. It owns the program counter, issues word-addressed reads to a synchronous instruction memory, and buffers returned instructions in a 2-entry queue. It presents them to decode with a valid/stall handshake. Taken branches and jumps resolved later in the pipeline reach it as a redirect, which squashes every fetched-but-unconsumed instruction.

## Interface
- `PC_W`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: read request to instruction memory this cycle.
- `imem_addr`  out  PC_W: word address of the request.
- `imem_rdata`  in  32: instruction word; valid exactly one cycle after its `imem_req`.
- `redirect_valid`  in  1: a taken branch, jump or JumpM target is being applied.
- `redirect_pc`  in  PC_W: new fetch address.
- `stall`  in  1: decode cannot accept this cycle.
- `valid_out`  out  1: `instr_out`/`pc_out` hold a real instruction.
- `instr_out`  out  32: instruction to decode. Opcode is in [31:28], rs in [27:22], rt in [21:16], rd in [15:10].
- `pc_out`  out  PC_W: address of `instr_out`.

## Operation
- State:
  - `fetch_pc`.
  - `inflight` flag plus its PC.
  - `squash` flag.
  - 2-entry FIFO of {pc, instr}, with count 0..2.
- Pop: occurs when `valid_out && !stall`.
- Issue condition: `!redirect_valid && (count + inflight - pop) < 2`.
- On issue:
  - `imem_req=1`, `imem_addr=fetch_pc`.
  - `fetch_pc <= fetch_pc + 1`; word addressing, wraps modulo 2^PC_W.
  - `inflight <= 1`.
- Return: in the cycle after an issue, `imem_rdata` plus the in-flight PC are pushed into the FIFO unless `squash` is set. An unissued cycle clears `inflight`.
- Output:
  - `valid_out = (count != 0)`.
  - `instr_out`/`pc_out` = FIFO head.
  - When empty, `instr_out = NOP_INSTR` (32'h0) and `pc_out` = 0.
- Redirect (priority over everything, including stall):
  - FIFO cleared.
  - `fetch_pc <= redirect_pc`.
  - A pending in-flight return is discarded via `squash`.
  - No request is issued that cycle. A pop in the same cycle is ignored.
- Push and pop in the same cycle: count is unchanged; the queue never overflows by construction of the issue rule.
- Back-to-back redirects: each overrides the last; only the final `redirect_pc` is fetched.
- Stall while full: no issue, and the outputs hold steady.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - `fetch_pc=RESET_PC`, count=0, `inflight=0`, `squash=0`.
  - `imem_req=0`, `valid_out=0`, `instr_out=0`, `pc_out=0`.
- Reset mid-operation drops all queued and in-flight instructions.
- First request: the first cycle after `rst_n` deasserts.
- Fetch latency: request in cycle k → `valid_out` with that instruction in cycle k+2.
- Redirect asserted in cycle r → request to `redirect_pc` in r+1 → valid in r+3. The redirect penalty is 2 bubbles beyond the stage's own latency.
- Sustained throughput: 1 instruction/cycle with `stall=0`.
- After `stall` deasserts from a full queue: no bubble for 2 cycles. Steady flow resumes without loss.

## Configuration
- `IF_PERF_CNT_EN` defined adds two ports, both 0 at reset:
  - `perf_fetch_cnt` out 32: counts pops.
  - `perf_stall_cnt` out 32: counts cycles with `valid_out && stall`.
- Both counters saturate at 32'hFFFF_FFFF.
- `IF_PERF_CNT_EN` undefined: the ports and counters are absent; functional behaviour is identical.

## Structure
- Shared `pipeline_pkg`:
  - `PC_W` and `INSTR_W=32`.
  - `NOP_INSTR=32'h0`.
  - `OPCODE_MSB/LSB=31/28`.
  - `fetch_entry_t` struct: {pc, instr}.
  - The package is reused by decode and the later pipeline registers.
- One sub-module, `if_skid_fifo`: 2-entry {pc, instr} queue with push/pop/flush and count output. PC sequencing, request issue and squash logic stay in `if_stage`.

## Test plan
- Reset with `RESET_PC=0`, stall=0, memory word[n]=n+32'h100 → `imem_addr` 0,1,2,…; `valid_out` from cycle 2 with `pc_out`=0,1,2 and `instr_out`=0x100,0x101,0x102 on consecutive cycles.
- Stall held 5 cycles mid-stream → at most 2 instructions buffered; `imem_req` drops. On release, PCs continue gap-free with no duplicate or lost PC.
- Redirect to 0x40 while the queue is full and a request is in flight:
  - next `valid_out` carries `pc_out`=0x40, exactly 3 cycles after the redirect;
  - no instruction from the old path appears.
- Redirect and stall asserted together, with redirect_pc=0x80 → redirect wins; the output shows 0x80 after the penalty.
- Fetch from `fetch_pc`=32'hFFFF_FFFF → next `imem_addr`=0 (wrap).
- Assert `rst_n`=0 mid-stream between clock edges → outputs go to reset values immediately. After release, fetch restarts at `RESET_PC`. With `IF_PERF_CNT_EN`, both counters read 0.
